psu_ucc_sweep: RTL and testbench
================================

# psu_ucc_sweep

Sequencer directly upstream of the PSU opcode/location decode stage. It accepts one PSU instruction (opcode plus per-PCU Pauli-change pair list), holds it stable as `opcode_running` / `pchop_list`, and steps every unit-cell controller (UCC) through its share of the unit-cell array, one step per downstream acceptance. The per-step `uc_counter` vector feeds the decode stage, which derives per-UCC boundary and diagonal location flags from it.

## Interface
Parameters:
- `NUM_UCROW`, default 4: unit-cell rows.
- `NUM_UCCOL`, default 4: unit-cell columns.
- `NUM_UCC`, default 4: unit-cell controllers. Must satisfy 1 ≤ `NUM_UCC` ≤ `NUM_UCROW`·`NUM_UCCOL`.
- `UCADDR_BW`, default 4: unit-cell address width. Must satisfy 2^`UCADDR_BW` ≥ `NUM_UCROW`·`NUM_UCCOL`.
- `NUM_PCU`, default 8: patch control units.
- `OPCODE_BW`, default 4: opcode width.
- `NOP_OPCODE`, default 0: opcode that completes without sweeping.

Ports:
- `clk`, in, 1: the block's single clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `start`, in, 1: instruction valid. Sampled only in IDLE.
- `opcode_in`, in, `OPCODE_BW`: instruction opcode.
- `pchop_in`, in, `NUM_PCU`·2·`OPCODE_BW`: per-PCU Pauli-change pairs.
- `flush`, in, 1: synchronous abort.
- `out_ready`, in, 1: downstream accepts the current step.
- `opcode_running`, out, `OPCODE_BW`: latched opcode.
- `pchop_list`, out, `NUM_PCU`·2·`OPCODE_BW`: latched pair list.
- `uc_counter`, out, `NUM_UCC`·`UCADDR_BW`: per-UCC unit-cell address. UCC i occupies bits [i·`UCADDR_BW` +: `UCADDR_BW`].
- `ucc_valid`, out, `NUM_UCC`: per-UCC address valid for this step.
- `out_valid`, out, 1: a step is presented.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle completion pulse.

## Operation
- Derived constants:
  - NUM_UC = `NUM_UCROW`·`NUM_UCCOL`.
  - NUM_STEP = ceil(NUM_UC / `NUM_UCC`).
- Internal step counter `step` is `UCADDR_BW` bits wide.
- States:
  - IDLE: `busy`=0, `out_valid`=0.
  - SWEEP: `out_valid`=1.
  - DONE: `done`=1 for exactly one cycle.
- IDLE, `start`=1:
  - Latch `opcode_in` into `opcode_running` and `pchop_in` into `pchop_list`.
  - Set `step`=0.
  - If `opcode_in`==`NOP_OPCODE`, go to DONE; otherwise go to SWEEP.
- SWEEP, combinational outputs from `step`:
  - Address a = `step`·`NUM_UCC` + i, computed at `UCADDR_BW`+1 bits with no truncation before the compare.
  - If a < NUM_UC: UCC i field = a and `ucc_valid`[i]=1.
  - Otherwise: UCC i field = 0 and `ucc_valid`[i]=0.
- SWEEP, handshake:
  - Transfer occurs when `out_valid` && `out_ready`.
  - On a transfer, `step` increments.
  - A transfer with `step`==NUM_STEP−1 goes to DONE instead; `step` returns to 0.
  - Without `out_ready`, all outputs hold.
- DONE always goes to IDLE on the next cycle.
- `opcode_running` and `pchop_list` hold from latch until the next accepted `start`, including through IDLE. They are never modified mid-sweep.
- `start` in SWEEP or DONE is ignored and is not queued.
- `flush`=1 in SWEEP or DONE forces IDLE next cycle:
  - No `done` pulse.
  - `step` is cleared.
  - Latched opcode and pair list are retained.
- `flush` in IDLE has no effect. `flush` takes priority over `out_ready` and over `start`.
- `rst` asserted (asynchronously, at any point):
  - State = IDLE, `step`=0.
  - `opcode_running`=0, `pchop_list`=0.
  - Since IDLE, `out_valid`=0, `busy`=0, `done`=0.
  - Reset mid-sweep discards the instruction.

## Timing
- Reset values:
  - `opcode_running`=0, `pchop_list`=0, `out_valid`=0, `busy`=0, `done`=0, `ucc_valid`=0.
  - `uc_counter` = all zero, because IDLE drives zeros.
- In IDLE, `uc_counter` and `ucc_valid` are driven to 0.
- `start` sampled at edge N:
  - `busy`=1 and `out_valid`=1 from cycle N+1, with step 0 presented.
  - NOP: `done`=1 in cycle N+1, `busy`=0 in N+2.
- With `out_ready` held at 1:
  - Steps occupy cycles N+1 … N+NUM_STEP.
  - `done` occurs in cycle N+NUM_STEP+1.
  - Earliest next `start` is accepted at edge N+NUM_STEP+2.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Test plan
- Defaults (4×4 array, 4 UCCs), `start` with opcode 3, `out_ready`=1:
  - Step 0 shows `uc_counter`={3,2,1,0} (UCC3…UCC0), `ucc_valid`=4'hF.
  - Step 3 shows {15,14,13,12}.
  - `done` in cycle N+5.
- `NUM_UCC`=3, 4×4, `out_ready`=1:
  - NUM_STEP=6.
  - Step 5 shows UCC0=15, UCC1=0, UCC2=0, `ucc_valid`=3'b001.
- Backpressure: `out_ready`=0 for 3 cycles during step 1 → step 1 outputs unchanged for all 3 cycles; `done` is delayed by 3 cycles.
- NOP: `start` with `opcode_in`=0 → `out_valid` stays 0; `done` in N+1; `busy` high one cycle.
- `flush` asserted at step 2 with `start` simultaneously high → IDLE next cycle, no `done`, `start` ignored; `opcode_running` retains the old value.
- `rst` pulsed mid-edge during step 1 → all outputs zero immediately. After release, a new `start` begins again at step 0.

Source files
------------

// File: rtl/psu_ucc_sweep.sv
// rtl/psu_ucc_sweep.sv - PSU instruction sequencer stepping unit-cell controllers over the unit-cell array
//
// Purpose:
//   Accepts one PSU instruction (opcode + per-PCU Pauli-change pair list), holds
//   it stable on opcode_running / pchop_list, and presents one sweep step per
//   downstream acceptance. Each step gives every UCC one unit-cell address.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             instruction valid (sampled only when idle)
//   opcode_in         instruction opcode
//   pchop_in          per-PCU Pauli-change pairs
//   flush             synchronous abort of a running instruction
//   out_ready         downstream accepts the presented step
//   opcode_running    latched opcode
//   pchop_list        latched pair list
//   uc_counter        per-UCC unit-cell address, UCC i at [i*UCADDR_BW +: UCADDR_BW]
//   ucc_valid         per-UCC address valid
//   out_valid         a step is presented
//   busy              instruction in progress
//   done              one-cycle completion pulse

module psu_ucc_sweep #(
    parameter int NUM_UCROW  = 4,
    parameter int NUM_UCCOL  = 4,
    parameter int NUM_UCC    = 4,
    parameter int UCADDR_BW  = 4,
    parameter int NUM_PCU    = 8,
    parameter int OPCODE_BW  = 4,
    parameter int NOP_OPCODE = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [OPCODE_BW-1:0]             opcode_in,
    input  logic [NUM_PCU*2*OPCODE_BW-1:0]   pchop_in,
    input  logic                             flush,
    input  logic                             out_ready,
    output logic [OPCODE_BW-1:0]             opcode_running,
    output logic [NUM_PCU*2*OPCODE_BW-1:0]   pchop_list,
    output logic [NUM_UCC*UCADDR_BW-1:0]     uc_counter,
    output logic [NUM_UCC-1:0]               ucc_valid,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             done
);

    localparam int NUM_UC   = NUM_UCROW * NUM_UCCOL;
    localparam int NUM_STEP = (NUM_UC + NUM_UCC - 1) / NUM_UCC;
    localparam int PCH_BW   = NUM_PCU * 2 * OPCODE_BW;

    localparam logic [UCADDR_BW-1:0] LAST_STEP = UCADDR_BW'(NUM_STEP - 1);
    // One extra bit so the last partial step's overflow addresses compare
    // correctly instead of wrapping into valid-looking cells.
    localparam logic [UCADDR_BW:0]   NUM_UC_W  = (UCADDR_BW + 1)'(NUM_UC);
    localparam logic [UCADDR_BW:0]   NUM_UCC_W = (UCADDR_BW + 1)'(NUM_UCC);
    localparam logic [OPCODE_BW-1:0] NOP_W     = OPCODE_BW'(NOP_OPCODE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [UCADDR_BW-1:0]   step_q, step_d;
    logic [OPCODE_BW-1:0]   opcode_q, opcode_d;
    logic [PCH_BW-1:0]      pchop_q, pchop_d;
    logic [UCADDR_BW:0]     addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            opcode_q <= '0;
            pchop_q  <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            opcode_q <= opcode_d;
            pchop_q  <= pchop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        opcode_d = opcode_q;
        pchop_d  = pchop_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opcode_d = opcode_in;
                    pchop_d  = pchop_in;
                    step_d   = '0;
                    state_d  = (opcode_in == NOP_W) ? ST_DONE : ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else if (out_ready) begin
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Flush here also lands in IDLE; the pulse is already on the wire.
                state_d = ST_IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    always_comb begin
        uc_counter = '0;
        ucc_valid  = '0;
        addr       = '0;
        if (state_q == ST_SWEEP) begin
            for (int i = 0; i < NUM_UCC; i++) begin
                addr = ({1'b0, step_q} * NUM_UCC_W) + (UCADDR_BW + 1)'(i);
                if (addr < NUM_UC_W) begin
                    uc_counter[i*UCADDR_BW +: UCADDR_BW] = addr[UCADDR_BW-1:0];
                    ucc_valid[i] = 1'b1;
                end
            end
        end
    end

    assign opcode_running = opcode_q;
    assign pchop_list     = pchop_q;
    assign out_valid      = (state_q == ST_SWEEP);
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_psu_ucc_sweep.sv
// tb/tb_psu_ucc_sweep.sv - self-checking bench for psu_ucc_sweep
module tb_psu_ucc_sweep;

    logic        clk;
    logic        rst;
    logic        start, flush, out_ready;
    logic [3:0]  opcode_in;
    logic [63:0] pchop_in;
    logic [3:0]  opcode_running;
    logic [63:0] pchop_list;
    logic [15:0] uc_counter;
    logic [3:0]  ucc_valid;
    logic        out_valid, busy, done;

    logic        s3_start, s3_flush, s3_ready;
    logic [3:0]  s3_opcode;
    logic [63:0] s3_pchop;
    logic [3:0]  s3_op_run;
    logic [63:0] s3_pch_list;
    logic [11:0] s3_uc;
    logic [2:0]  s3_vld;
    logic        s3_out_valid, s3_busy, s3_done;

    int checks = 0;
    int errors = 0;
    logic [3:0]  g_op;
    logic [63:0] g_pch;

    psu_ucc_sweep dut (
        .clk(clk), .rst(rst), .start(start), .opcode_in(opcode_in),
        .pchop_in(pchop_in), .flush(flush), .out_ready(out_ready),
        .opcode_running(opcode_running), .pchop_list(pchop_list),
        .uc_counter(uc_counter), .ucc_valid(ucc_valid),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    psu_ucc_sweep #(.NUM_UCC(3)) dut3 (
        .clk(clk), .rst(rst), .start(s3_start), .opcode_in(s3_opcode),
        .pchop_in(s3_pchop), .flush(s3_flush), .out_ready(s3_ready),
        .opcode_running(s3_op_run), .pchop_list(s3_pch_list),
        .uc_counter(s3_uc), .ucc_valid(s3_vld),
        .out_valid(s3_out_valid), .busy(s3_busy), .done(s3_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected per-UCC address vector for sweep step k of a 16-cell array.
    function automatic logic [31:0] exp_uc(input int k, input int nucc);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nucc; i++) begin
            int a;
            a = k * nucc + i;
            if (a < 16) v[i*4 +: 4] = a[3:0];
        end
        return v;
    endfunction

    function automatic logic [7:0] exp_vld(input int k, input int nucc);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < nucc; i++)
            if (k * nucc + i < 16) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({opcode_running, pchop_list, uc_counter, ucc_valid, out_valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got op=%h pch=%h uc=%h vld=%h ov=%b busy=%b done=%b required all zero",
                     opcode_running, pchop_list, uc_counter, ucc_valid, out_valid, busy, done);
        end
        tick;
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if ({busy, out_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got %b required 000", {busy, out_valid, done});
        end
    endtask

    task automatic test_basic;
        logic [31:0] eu;
        logic [7:0]  ev;
        logic [63:0] pch;
        pch = {$urandom, $urandom};
        opcode_in = 4'd3; pchop_in = pch; start = 1'b1; out_ready = 1'b1;
        tick;
        start = 1'b0;
        g_op = 4'd3; g_pch = pch;
        for (int k = 0; k < 4; k++) begin
            eu = exp_uc(k, 4); ev = exp_vld(k, 4);
            checks++;
            if ({out_valid, busy, done} !== 3'b110 || uc_counter !== eu[15:0] || ucc_valid !== ev[3:0]) begin
                errors++;
                $display("FAIL basic_step%0d got ctl=%b uc=%h vld=%h required ctl=110 uc=%h vld=%h",
                         k, {out_valid, busy, done}, uc_counter, ucc_valid, eu[15:0], ev[3:0]);
            end
            if (k == 0) begin
                checks++;
                if (opcode_running !== 4'd3 || pchop_list !== pch || uc_counter !== 16'h3210) begin
                    errors++;
                    $display("FAIL basic_latch got op=%h pch=%h uc=%h required op=3 pch=%h uc=3210",
                             opcode_running, pchop_list, uc_counter, pch);
                end
            end
            if (k == 3) begin
                checks++;
                if (uc_counter !== 16'hFEDC) begin
                    errors++;
                    $display("FAIL basic_last_step got %h required fedc", uc_counter);
                end
            end
            tick;
        end
        checks++;
        if ({out_valid, busy, done} !== 3'b011) begin
            errors++;
            $display("FAIL basic_done got %b required 011", {out_valid, busy, done});
        end
        tick;
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL basic_idle got %b required 000", {out_valid, busy, done});
        end
    endtask

    task automatic test_backpressure;
        opcode_in = 4'd2; pchop_in = 64'h0123_4567_89ab_cdef; start = 1'b1; out_ready = 1'b1;
        tick;
        start = 1'b0;
        g_op = 4'd2; g_pch = 64'h0123_4567_89ab_cdef;
        tick;
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) out_ready = 1'b1;
            checks++;
            if (uc_counter !== 16'h7654 || ucc_valid !== 4'hF || out_valid !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle%0d got uc=%h vld=%h ov=%b done=%b required uc=7654 vld=f ov=1 done=0",
                         j, uc_counter, ucc_valid, out_valid, done);
            end
            if (j < 3) tick;
        end
        tick;
        tick;
        tick;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done_delay got done=%b ov=%b required done=1 ov=0", done, out_valid);
        end
        tick;
    endtask

    task automatic test_nop;
        opcode_in = 4'd0; pchop_in = 64'hAAAA_5555_AAAA_5555; start = 1'b1;
        tick;
        start = 1'b0;
        g_op = 4'd0; g_pch = 64'hAAAA_5555_AAAA_5555;
        checks++;
        if ({out_valid, busy, done} !== 3'b011 || opcode_running !== 4'd0 || pchop_list !== g_pch) begin
            errors++;
            $display("FAIL nop_done got ctl=%b op=%h pch=%h required ctl=011 op=0 pch=%h",
                     {out_valid, busy, done}, opcode_running, pchop_list, g_pch);
        end
        tick;
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL nop_idle got %b required 000", {out_valid, busy, done});
        end
    endtask

    task automatic test_flush;
        logic [63:0] pch;
        pch = {$urandom, $urandom};
        opcode_in = 4'd5; pchop_in = pch; start = 1'b1; out_ready = 1'b1;
        tick;
        start = 1'b0;
        g_op = 4'd5; g_pch = pch;
        tick;
        tick;
        checks++;
        if (uc_counter !== 16'hBA98) begin
            errors++;
            $display("FAIL flush_at_step2 got %h required ba98", uc_counter);
        end
        flush = 1'b1; start = 1'b1; opcode_in = 4'd7; pchop_in = ~pch;
        tick;
        flush = 1'b0; start = 1'b0;
        checks++;
        if ({out_valid, busy, done} !== 3'b000 || ucc_valid !== 4'h0 || opcode_running !== 4'd5 || pchop_list !== pch) begin
            errors++;
            $display("FAIL flush_idle got ctl=%b vld=%h op=%h required ctl=000 vld=0 op=5",
                     {out_valid, busy, done}, ucc_valid, opcode_running);
        end
        tick;
        checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL flush_start_ignored got %b required 000", {out_valid, busy, done});
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] pch;
        opcode_in = 4'd9; pchop_in = 64'hDEAD_BEEF_0000_1111; start = 1'b1; out_ready = 1'b1;
        tick;
        start = 1'b0;
        tick;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({opcode_running, pchop_list, uc_counter, ucc_valid, out_valid, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_mid got op=%h pch=%h uc=%h vld=%h ctl=%b required all zero",
                     opcode_running, pchop_list, uc_counter, ucc_valid, {out_valid, busy, done});
        end
        tick;
        rst = 1'b0;
        pch = {$urandom, $urandom};
        opcode_in = 4'd6; pchop_in = pch; start = 1'b1;
        tick;
        start = 1'b0;
        g_op = 4'd6; g_pch = pch;
        checks++;
        if (uc_counter !== 16'h3210 || out_valid !== 1'b1 || opcode_running !== 4'd6) begin
            errors++;
            $display("FAIL rst_restart got uc=%h ov=%b op=%h required uc=3210 ov=1 op=6",
                     uc_counter, out_valid, opcode_running);
        end
        repeat (5) tick;
    endtask

    task automatic test_ucc3;
        logic [31:0] eu;
        logic [7:0]  ev;
        s3_opcode = 4'd3; s3_pchop = 64'h1; s3_start = 1'b1; s3_ready = 1'b1;
        tick;
        s3_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            eu = exp_uc(k, 3); ev = exp_vld(k, 3);
            checks++;
            if (s3_uc !== eu[11:0] || s3_vld !== ev[2:0] || s3_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL ucc3_step%0d got uc=%h vld=%b ov=%b required uc=%h vld=%b ov=1",
                         k, s3_uc, s3_vld, s3_out_valid, eu[11:0], ev[2:0]);
            end
            if (k == 5) begin
                checks++;
                if (s3_uc !== 12'h00F || s3_vld !== 3'b001) begin
                    errors++;
                    $display("FAIL ucc3_partial got uc=%h vld=%b required 00f 001", s3_uc, s3_vld);
                end
            end
            tick;
        end
        checks++;
        if (s3_done !== 1'b1 || s3_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ucc3_done got done=%b ov=%b required 1 0", s3_done, s3_out_valid);
        end
        tick;
        checks++;
        if (s3_busy !== 1'b0) begin
            errors++;
            $display("FAIL ucc3_idle got busy=%b required 0", s3_busy);
        end
    endtask

    // Reference: an instruction is a queue of step indices still to be
    // presented, followed by one done cycle.
    task automatic test_random;
        int          q[$];
        bit          d;
        logic [3:0]  op_m, opc;
        logic [63:0] pch_m, pc;
        logic [31:0] eu;
        logic [7:0]  ev;
        bit          s, rdy, fl;
        q = {};
        d = 1'b0;
        op_m = g_op; pch_m = g_pch;
        for (int n = 0; n < 400; n++) begin
            s   = ($urandom_range(0, 2) == 0);
            opc = 4'($urandom_range(0, 3));
            pc  = {$urandom, $urandom};
            rdy = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 19) == 0);
            start = s; opcode_in = opc; pchop_in = pc; out_ready = rdy; flush = fl;
            @(posedge clk);
            if (d) begin
                d = 1'b0;
            end else if (q.size() > 0) begin
                if (fl) q.delete();
                else if (rdy) begin
                    void'(q.pop_front());
                    if (q.size() == 0) d = 1'b1;
                end
            end else if (s) begin
                op_m = opc; pch_m = pc;
                if (opc == 4'd0) d = 1'b1;
                else for (int k = 0; k < 4; k++) q.push_back(k);
            end
            #1;
            checks++;
            if ({out_valid, busy, done} !== {q.size() > 0, (q.size() > 0) || d, d}) begin
                errors++;
                $display("FAIL rand_ctl cyc%0d got %b required %b", n, {out_valid, busy, done},
                         {q.size() > 0, (q.size() > 0) || d, d});
            end
            eu = (q.size() > 0) ? exp_uc(q[0], 4) : 32'h0;
            ev = (q.size() > 0) ? exp_vld(q[0], 4) : 8'h0;
            checks++;
            if (uc_counter !== eu[15:0] || ucc_valid !== ev[3:0]) begin
                errors++;
                $display("FAIL rand_uc cyc%0d got uc=%h vld=%h required uc=%h vld=%h",
                         n, uc_counter, ucc_valid, eu[15:0], ev[3:0]);
            end
            checks++;
            if (opcode_running !== op_m || pchop_list !== pch_m) begin
                errors++;
                $display("FAIL rand_latch cyc%0d got op=%h pch=%h required op=%h pch=%h",
                         n, opcode_running, pchop_list, op_m, pch_m);
            end
        end
        start = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; out_ready = 1'b1;
        opcode_in = '0; pchop_in = '0;
        s3_start = 1'b0; s3_flush = 1'b0; s3_ready = 1'b1; s3_opcode = '0; s3_pchop = '0;
        g_op = '0; g_pch = '0;
        test_reset;
        test_basic;
        test_backpressure;
        test_nop;
        test_flush;
        test_reset_mid;
        test_ucc3;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
